// File: rtl/spi_pkg.sv
// Shared types for the SPI RAM master: frame commands, FSM states and the
// latched host request, plus the helper that builds an 11-bit frame word.
package spi_pkg;

  typedef enum logic [1:0] {
    WRITE_A = 2'b00,
    WRITE   = 2'b01,
    READ_A  = 2'b10,
    READ    = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_SHIFT,
    ST_TAIL,
    ST_WAIT,
    ST_RECV,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [7:0] address;
    logic [7:0] data;
  } packet_t;

  localparam int FRAME_BITS = 11;

  // Word shifted out after c0: {sel, cmd, payload}; sel mirrors cmd[1].
  function automatic logic [FRAME_BITS-1:0] frame_word(mode_e mode, logic [7:0] payload);
    logic [1:0] code;
    code = 2'(mode);
    return {code[1], code, payload};
  endfunction

endpackage

// File: rtl/spi_ram_master_if.sv
// Host request/response bus and SPI pins of the SPI RAM master.
// Handshake: a request transfers on a posedge where req_valid && req_ready;
// req_ready only rises in IDLE, so req_valid held while busy is simply ignored.
interface spi_ram_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, MISO,
    output req_ready, rsp_valid, rsp_rdata, busy, SS_n, MOSI
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, MISO,
    input  req_ready, rsp_valid, rsp_rdata, busy, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master_shifter.sv
// 11-bit MOSI serializer and 8-bit MISO deserializer sharing one bit counter.
// MOSI is a register: it shows the loaded MSB the cycle after load and 0 when idle.
module spi_master_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [10:0] word,
  input  logic        shift,
  input  logic        cnt_clr,
  input  logic        rx_clr,
  input  logic        rx_en,
  input  logic        miso,
  output logic        mosi,
  output logic [7:0]  rx_data,
  output logic [3:0]  bit_cnt
);

  logic [10:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      mosi    <= 1'b0;
      bit_cnt <= '0;
      rx_data <= '0;
    end else begin
      if (load) begin
        mosi <= word[10];
        sr_q <= {word[9:0], 1'b0};
      end else if (shift) begin
        mosi <= sr_q[10];
        sr_q <= {sr_q[9:0], 1'b0};
      end else begin
        mosi <= 1'b0;
      end

      if (load || cnt_clr) begin
        bit_cnt <= '0;
      end else if (shift || rx_en) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

      // MSB arrives first, so new bits enter on the LSB side.
      if (rx_clr) begin
        rx_data <= '0;
      end else if (rx_en) begin
        rx_data <= {rx_data[6:0], miso};
      end
    end
  end

endmodule

// File: rtl/spi_ram_master.sv
// Host-side SPI master: turns one host write/read request into an address
// frame followed by a data frame on the SPI RAM slave, returning read data.
module spi_ram_master
  import spi_pkg::*;
#(
  parameter int TAIL   = 2,
  parameter int GAP    = 1,
  parameter int RD_LAT = 7
) (
  input  logic              clk,
  input  logic              rst,
  spi_ram_master_if.master  bus,
  output state_e            dbg_state
);

  localparam logic [7:0] TAIL_LAST = 8'(TAIL - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);
  localparam logic [7:0] WAIT_LAST = 8'(RD_LAT - 2);

  state_e     state_q, state_d;
  logic       frame_q, frame_d;
  logic       rw_q, rw_d;
  packet_t    pkt_q, pkt_d;
  logic [7:0] timer_q, timer_d;
  logic       ss_n_q, ss_n_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       rsp_q, rsp_d;

  logic        sh_load, sh_shift, sh_cnt_clr, rx_clr, rx_en;
  logic [3:0]  bit_cnt;
  logic        mosi;
  logic [7:0]  rx_data;
  mode_e       cur_mode;
  logic [7:0]  payload;

  // Frame index 0 carries the address, 1 carries data; rw picks the read commands.
  assign cur_mode = mode_e'({rw_q, frame_q});
  assign payload  = frame_q ? (rw_q ? 8'h00 : pkt_q.data) : pkt_q.address;

  spi_master_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .word    (frame_word(cur_mode, payload)),
    .shift   (sh_shift),
    .cnt_clr (sh_cnt_clr),
    .rx_clr  (rx_clr),
    .rx_en   (rx_en),
    .miso    (bus.MISO),
    .mosi    (mosi),
    .rx_data (rx_data),
    .bit_cnt (bit_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      frame_q <= 1'b0;
      rw_q    <= 1'b0;
      pkt_q   <= '0;
      timer_q <= '0;
      ss_n_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      rw_q    <= rw_d;
      pkt_q   <= pkt_d;
      timer_q <= timer_d;
      ss_n_q  <= ss_n_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    rw_d       = rw_q;
    pkt_d      = pkt_q;
    timer_d    = timer_q;
    ss_n_d     = ss_n_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    rsp_d      = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_cnt_clr = 1'b0;
    rx_clr     = 1'b0;
    rx_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && ready_q) begin
          rw_d          = bus.req_rw;
          pkt_d.address = bus.req_addr;
          pkt_d.data    = bus.req_wdata;
          frame_d       = 1'b0;
          ss_n_d        = 1'b0;
          ready_d       = 1'b0;
          busy_d        = 1'b1;
          rx_clr        = 1'b1;
          state_d       = ST_SEL;
        end
      end

      ST_SEL: begin
        sh_load = 1'b1;
        state_d = ST_SHIFT;
      end

      // bit_cnt==10 is c11, the last payload bit on the wire.
      ST_SHIFT: begin
        if (bit_cnt == 4'd10) begin
          sh_cnt_clr = 1'b1;
          timer_d    = '0;
          state_d    = (cur_mode == READ) ? ST_WAIT : ST_TAIL;
        end else begin
          sh_shift = 1'b1;
        end
      end

      ST_TAIL: begin
        if (timer_q == TAIL_LAST) begin
          ss_n_d  = 1'b1;
          timer_d = '0;
          state_d = ST_GAP;
          if (frame_q) begin
            rsp_d  = 1'b1;
            busy_d = 1'b0;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      ST_WAIT: begin
        if (timer_q == WAIT_LAST) begin
          timer_d = '0;
          state_d = ST_RECV;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      // Only the READ data frame reaches RECV, so it always completes the transaction.
      ST_RECV: begin
        rx_en = 1'b1;
        if (bit_cnt == 4'd7) begin
          ss_n_d  = 1'b1;
          timer_d = '0;
          rsp_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (frame_q) begin
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_d = 1'b1;
            ss_n_d  = 1'b0;
            state_d = ST_SEL;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_rdata = rx_data;
  assign bus.SS_n      = ss_n_q;
  assign bus.MOSI      = mosi;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: behavioural SPI RAM slave, frame/timing monitor,
// response scoreboard, vector table, reset-abort sequence and random traffic.
module tb_spi_ram_master;
  import spi_pkg::*;

  localparam int TAIL   = 2;
  localparam int GAP    = 1;
  localparam int RD_LAT = 7;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  spi_ram_master_if bus ();

  spi_ram_master #(.TAIL(TAIL), .GAP(GAP), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- check bookkeeping ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [11:0] mk(input logic [1:0] cmd, input logic [7:0] p);
    return {1'b0, cmd[1], cmd, p};
  endfunction

  // ---------------- behavioural SPI RAM slave + frame monitor ----------------
  logic [7:0]  sram [256];
  logic [7:0]  ref_mem [256];
  logic [11:0] frm_q[$];
  logic        force_miso = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 8'h00;
      ref_mem[i] = 8'h00;
    end
  end

  int          s_idx = 0;
  int          high_cnt = 0;
  logic        prev_ss = 1'b1;
  logic        have_prev = 1'b0;
  logic [11:0] bits = '0;
  logic [1:0]  last_cmd = 2'b00;
  logic [7:0]  wr_addr = '0, rd_addr = '0, rd_byte = '0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_ss   = 1'b1;
      have_prev = 1'b0;
      high_cnt  = 0;
      bus.MISO  = 1'b0;
    end else if (bus.SS_n == 1'b0) begin
      if (prev_ss) begin
        s_idx = 0;
        if (have_prev) check("gap_min", 32'(high_cnt >= GAP), 32'd1);
      end else begin
        s_idx++;
      end
      if (s_idx < 12) bits[11 - s_idx] = bus.MOSI;
      if (s_idx == 11) begin
        last_cmd = bits[9:8];
        case (bits[9:8])
          2'b00: wr_addr = bits[7:0];
          2'b01: sram[wr_addr] = bits[7:0];
          2'b10: rd_addr = bits[7:0];
          default: rd_byte = sram[rd_addr];
        endcase
      end
      if (s_idx > 11 && last_cmd == 2'b11 && s_idx >= 11 + RD_LAT && s_idx <= 18 + RD_LAT)
        bus.MISO = force_miso | rd_byte[7 - (s_idx - 11 - RD_LAT)];
      else
        bus.MISO = force_miso;
      prev_ss = 1'b0;
    end else begin
      if (!prev_ss) begin
        high_cnt = 1;
        if (s_idx >= 11) begin
          frm_q.push_back(bits);
          check("frame_len", 32'(s_idx + 1),
                (last_cmd == 2'b11) ? 32'(RD_LAT + 19) : 32'(12 + TAIL));
          have_prev = 1'b1;
        end
      end else begin
        high_cnt++;
      end
      bus.MISO = force_miso;
      prev_ss  = 1'b1;
    end
  end

  // ---------------- response scoreboard ----------------
  logic [7:0] exp_q[$];
  int         rsp_cnt = 0;
  logic       prev_rsp = 1'b0;

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      check("rsp_pulse_width", 32'(prev_rsp), 32'd0);
      check("rsp_ss_high", 32'(bus.SS_n), 32'd1);
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_q.pop_front()));
      end
      rsp_cnt++;
    end
    prev_rsp = (bus.rsp_valid === 1'b1);
  end

  // ---------------- driver ----------------
  task automatic do_txn(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [7:0] rdata_exp, input logic [11:0] f1, input logic [11:0] f2);
    int n;
    int base;
    frm_q.delete();
    exp_q.push_back(rdata_exp);
    base = rsp_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 200), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_rw    = ~rw;
    bus.req_addr  = ~addr;
    bus.req_wdata = ~wdata;
    check("ready_drop", 32'(bus.req_ready), 32'd0);
    check("busy_set", 32'(bus.busy), 32'd1);
    n = 0;
    while (rsp_cnt == base && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait", 32'(n < 300), 32'd1);
    check("frame_count", 32'(frm_q.size()), 32'd2);
    if (frm_q.size() == 2) begin
      check("frame1_mosi", 32'(frm_q[0]), 32'(f1));
      check("frame2_mosi", 32'(frm_q[1]), 32'(f2));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [11:0] f1;
    logic [11:0] f2;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [7:0] a, d;
    int n;

    vt[0] = '{1'b0, 8'hA5, 8'h3C, 12'h0A5, 12'h13C, 8'h00};
    vt[1] = '{1'b0, 8'h10, 8'h5A, 12'h010, 12'h15A, 8'h00};
    vt[2] = '{1'b1, 8'h10, 8'hEE, 12'h610, 12'h700, 8'h5A};
    vt[3] = '{1'b0, 8'hFF, 8'h81, 12'h0FF, 12'h181, 8'h00};
    vt[4] = '{1'b1, 8'hFF, 8'h00, 12'h6FF, 12'h700, 8'h81};
    vt[5] = '{1'b1, 8'hA5, 8'h77, 12'h6A5, 12'h700, 8'h3C};

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({bus.SS_n, bus.MOSI, bus.req_ready, bus.busy, bus.rsp_valid}),
          32'(5'b10100));
    check("reset_rdata", 32'(bus.rsp_rdata), 32'h00);
    rst = 1'b0;

    // Idle for 20 cycles with no request.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'({bus.SS_n, bus.MOSI, bus.req_ready, bus.busy, bus.rsp_valid}),
            32'(5'b10100));
    end

    for (int i = 0; i < 6; i++) begin
      if (!vt[i].rw) ref_mem[vt[i].addr] = vt[i].wdata;
      do_txn(vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].f1, vt[i].f2);
    end

    // Read with MISO stuck high.
    force_miso = 1'b1;
    do_txn(1'b1, 8'h20, 8'h00, 8'hFF, 12'h620, 12'h700);
    force_miso = 1'b0;

    // Reset in the middle of the first frame's shift.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 8'h44;
    bus.req_wdata = 8'h99;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_in_shift", 32'(dbg_state), 32'(ST_SHIFT));
    check("abort_ss_low", 32'(bus.SS_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", 32'({bus.SS_n, bus.MOSI, bus.req_ready, bus.busy, bus.rsp_valid}),
          32'(5'b10100));
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_rsp_ready", 32'(bus.req_ready), 32'd1);
    do_txn(1'b1, 8'h44, 8'h00, 8'h00, 12'h644, 12'h700);

    // Random write/read pairs against the reference memory.
    for (int i = 0; i < 100; i++) begin
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      ref_mem[a] = d;
      do_txn(1'b0, a, d, 8'h00, mk(2'b00, a), mk(2'b01, d));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = (i % 4 == 3) ? 8'($urandom_range(0, 255)) : a;
      do_txn(1'b1, a, 8'($urandom), ref_mem[a], mk(2'b10, a), mk(2'b11, 8'h00));
    end

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
